fu_exec_sequencer: RTL and testbench

Multi-cycle execute-stage controller that sequences the combinational Function Unit for one decoded Format I/II instruction. It fetches memory operands for the addressing modes it supports, drives the Function Unit's FS, src and dst inputs, and captures its result and flags. It then writes the result back to the register file or to memory and updates SR flags. It sits between the instruction decoder and the Function Unit/memory bus, and handles one instruction at a time.

---
 rtl/fu_exec_sequencer_pkg.sv | 42 ++++
 rtl/fu_operand_addr_gen.sv | 22 ++
 rtl/fu_exec_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fu_exec_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_exec_sequencer_pkg.sv
// rtl/fu_exec_sequencer_pkg.sv - shared FS codes, state encodings, mode codes and flag indices
package fu_exec_sequencer_pkg;

    localparam logic [15:0] FS_MOV  = 16'h0001;
    localparam logic [15:0] FS_ADD  = 16'h0002;
    localparam logic [15:0] FS_ADDC = 16'h0004;
    localparam logic [15:0] FS_SUB  = 16'h0008;
    localparam logic [15:0] FS_CMP  = 16'h0010;
    localparam logic [15:0] FS_AND  = 16'h0020;
    localparam logic [15:0] FS_BIT  = 16'h0040;
    localparam logic [15:0] FS_XOR  = 16'h0080;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SRC_RD = 3'd1,
        ST_DST_RD = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB_MEM = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [1:0] SRC_REG      = 2'd0;
    localparam logic [1:0] SRC_INDEXED  = 2'd1;
    localparam logic [1:0] SRC_INDIRECT = 2'd2;
    localparam logic [1:0] SRC_AUTOINC  = 2'd3;

    localparam logic DST_REG     = 1'b0;
    localparam logic DST_INDEXED = 1'b1;

    // Positions inside every {Z,V,N,C} nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam logic [15:0] BYTE_MASK = 16'h00FF;

    function automatic logic [15:0] mask_operand(input logic [15:0] data, input logic byte_op);
        return byte_op ? (data & BYTE_MASK) : data;
    endfunction

endpackage

// File: rtl/fu_operand_addr_gen.sv
// rtl/fu_operand_addr_gen.sv - mode-to-address and autoincrement value computation
module fu_operand_addr_gen
    import fu_exec_sequencer_pkg::*;
(
    input  logic [1:0]  src_mode,
    input  logic        byte_op,
    input  logic [15:0] src_reg,
    input  logic [15:0] src_idx,
    input  logic [15:0] dst_reg,
    input  logic [15:0] dst_idx,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr,
    output logic [15:0] inc_val
);

    always_comb begin
        src_addr = (src_mode == SRC_INDEXED) ? (src_reg + src_idx) : src_reg;
        dst_addr = dst_reg + dst_idx;
        inc_val  = src_reg + (byte_op ? 16'd1 : 16'd2);
    end

endmodule

// File: rtl/fu_exec_sequencer.sv
// rtl/fu_exec_sequencer.sv - execute-stage sequencer around the Function Unit
// Optional memory-wait abort enabled by defining FU_SEQ_TIMEOUT_EN.
module fu_exec_sequencer
    import fu_exec_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] fs,
    input  logic        byte_op,
    input  logic [1:0]  src_mode,
    input  logic        dst_mode,
    input  logic        dst_wr,
    input  logic [15:0] src_reg,
    input  logic [15:0] dst_reg,
    input  logic [15:0] src_idx,
    input  logic [15:0] dst_idx,
    input  logic [3:0]  flags_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] fu_src,
    output logic [15:0] fu_dst,
    output logic [15:0] fu_fs,
    output logic [3:0]  fu_flags_in,
    input  logic [15:0] fu_result,
    input  logic [3:0]  fu_flags,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        inc_we,
    output logic [15:0] inc_val,
    output logic        flags_we,
    output logic [3:0]  flags_out,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef FU_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [15:0]        fs_q, fs_d;
    logic               byte_q, byte_d;
    logic [1:0]         src_mode_q, src_mode_d;
    logic               dst_mode_q, dst_mode_d;
    logic               dst_wr_q, dst_wr_d;
    logic [15:0]        src_idx_q, src_idx_d;
    logic [15:0]        dst_idx_q, dst_idx_d;
    logic [3:0]         flags_in_q, flags_in_d;
    logic [15:0]        src_q, src_d;
    logic [15:0]        dst_q, dst_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;

    logic [15:0]        src_addr;
    logic [15:0]        dst_addr;
    logic [15:0]        inc_next;
    logic               mem_state;

    // src_q/dst_q hold the register values until a memory read replaces them,
    // so they double as the base addresses while the reads are outstanding.
    fu_operand_addr_gen u_addr_gen (
        .src_mode (src_mode_q),
        .byte_op  (byte_q),
        .src_reg  (src_q),
        .src_idx  (src_idx_q),
        .dst_reg  (dst_q),
        .dst_idx  (dst_idx_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .inc_val  (inc_next)
    );

    assign mem_state = (state_q == ST_SRC_RD) || (state_q == ST_DST_RD) || (state_q == ST_WB_MEM);

    always_comb begin
        state_d    = state_q;
        fs_d       = fs_q;
        byte_d     = byte_q;
        src_mode_d = src_mode_q;
        dst_mode_d = dst_mode_q;
        dst_wr_d   = dst_wr_q;
        src_idx_d  = src_idx_q;
        dst_idx_d  = dst_idx_q;
        flags_in_d = flags_in_q;
        src_d      = src_q;
        dst_d      = dst_q;
        addr_d     = addr_q;
        res_d      = res_q;
        cnt_d      = '0;
        error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fs_d       = fs;
                    byte_d     = byte_op;
                    src_mode_d = src_mode;
                    dst_mode_d = dst_mode;
                    dst_wr_d   = dst_wr;
                    src_idx_d  = src_idx;
                    dst_idx_d  = dst_idx;
                    flags_in_d = flags_in;
                    src_d      = src_reg;
                    dst_d      = dst_reg;
                    if (src_mode != SRC_REG) begin
                        state_d = ST_SRC_RD;
                    end else if (dst_mode == DST_INDEXED) begin
                        state_d = ST_DST_RD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_SRC_RD: begin
                if (mem_ack) begin
                    src_d   = mask_operand(mem_rdata, byte_q);
                    state_d = (dst_mode_q == DST_INDEXED) ? ST_DST_RD : ST_EXEC;
                end
            end
            ST_DST_RD: begin
                if (mem_ack) begin
                    dst_d   = mask_operand(mem_rdata, byte_q);
                    addr_d  = dst_addr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = fu_result;
                state_d = (dst_wr_q && (dst_mode_q == DST_INDEXED)) ? ST_WB_MEM : ST_DONE;
            end
            ST_WB_MEM: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter stays zero outside memory states and on every ack, so each access starts fresh
        if (TMO_EN && mem_state && !mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TMO_LAST) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fs_q       <= '0;
            byte_q     <= 1'b0;
            src_mode_q <= '0;
            dst_mode_q <= 1'b0;
            dst_wr_q   <= 1'b0;
            src_idx_q  <= '0;
            dst_idx_q  <= '0;
            flags_in_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            addr_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fs_q       <= fs_d;
            byte_q     <= byte_d;
            src_mode_q <= src_mode_d;
            dst_mode_q <= dst_mode_d;
            dst_wr_q   <= dst_wr_d;
            src_idx_q  <= src_idx_d;
            dst_idx_q  <= dst_idx_d;
            flags_in_q <= flags_in_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            addr_q     <= addr_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        inc_we    = 1'b0;
        inc_val   = '0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        flags_we  = 1'b0;
        flags_out = '0;

        case (state_q)
            ST_SRC_RD: begin
                mem_req  = 1'b1;
                mem_byte = byte_q;
                mem_addr = src_addr;
                if (mem_ack && (src_mode_q == SRC_AUTOINC)) begin
                    inc_we  = 1'b1;
                    inc_val = inc_next;
                end
            end
            ST_DST_RD: begin
                mem_req  = 1'b1;
                mem_byte = byte_q;
                mem_addr = dst_addr;
            end
            ST_EXEC: begin
                flags_we  = 1'b1;
                flags_out = fu_flags;
                if (dst_wr_q && (dst_mode_q == DST_REG)) begin
                    reg_we    = 1'b1;
                    reg_wdata = fu_result;
                end
            end
            ST_WB_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_byte  = byte_q;
                mem_addr  = addr_q;
                mem_wdata = res_q;
            end
            default: begin
            end
        endcase
    end

    assign fu_fs       = fs_q;
    assign fu_src      = src_q;
    assign fu_dst      = dst_q;
    assign fu_flags_in = flags_in_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;

endmodule

// File: tb/tb_fu_exec_sequencer.sv
// tb/tb_fu_exec_sequencer.sv - vector table plus event scoreboard for fu_exec_sequencer
module tb_fu_exec_sequencer;
    import fu_exec_sequencer_pkg::*;

    localparam int K_RD = 0, K_INC = 1, K_WR = 2, K_REGW = 3, K_FLG = 4, K_DONE = 5, K_ERR = 6;

    typedef struct {
        logic [15:0] fs;
        logic        bo;
        logic [1:0]  sm;
        logic        dm;
        logic        dwr;
        logic [15:0] sreg, dreg, sidx, didx;
        logic [3:0]  fin;
        logic [15:0] rd0, rd1;
        int          waits;
        logic [15:0] e_rd0, e_inc, e_rd1, e_regw;
        logic [3:0]  e_flg;
        logic [15:0] e_wa, e_wd;
        logic [4:0]  e_mask;
        int          e_lat;
    } vec_t;

    typedef struct {
        int          kind;
        logic [39:0] v;
    } ev_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] fs = '0, src_reg = '0, dst_reg = '0, src_idx = '0, dst_idx = '0;
    logic        byte_op = 1'b0, dst_mode = 1'b0, dst_wr = 1'b0;
    logic [1:0]  src_mode = '0;
    logic [3:0]  flags_in = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] fu_result;
    logic [3:0]  fu_flags;
    logic        mem_req, mem_we, mem_byte, reg_we, inc_we, flags_we, busy, done, error;
    logic [15:0] mem_addr, mem_wdata, fu_src, fu_dst, fu_fs, reg_wdata, inc_val;
    logic [3:0]  fu_flags_in, flags_out;

    int n_cmp = 0, n_err = 0, cyc = 0, start_c = 0, done_cnt = 0, err_cnt = 0;
    int cur_waits = 0, wcnt = 0, ridx = 0;
    logic [15:0] rd0 = '0, rd1 = '0;
    ev_t sb[$];
    vec_t vecs[8];
    string knm[7] = '{"rd", "inc", "wr", "regw", "flags", "done", "error"};

    fu_exec_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .start(start), .fs(fs), .byte_op(byte_op),
        .src_mode(src_mode), .dst_mode(dst_mode), .dst_wr(dst_wr),
        .src_reg(src_reg), .dst_reg(dst_reg), .src_idx(src_idx), .dst_idx(dst_idx),
        .flags_in(flags_in), .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fu_src(fu_src), .fu_dst(fu_dst), .fu_fs(fu_fs), .fu_flags_in(fu_flags_in),
        .fu_result(fu_result), .fu_flags(fu_flags), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .inc_we(inc_we), .inc_val(inc_val), .flags_we(flags_we), .flags_out(flags_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function Unit stand-in: MOV passes flags through, ADD/CMP compute {Z,V,N,C}
    logic [16:0] fu_tmp;
    always_comb begin
        fu_tmp    = '0;
        fu_result = '0;
        fu_flags  = fu_flags_in;
        if (fu_fs == FS_ADD) begin
            fu_tmp    = {1'b0, fu_src} + {1'b0, fu_dst};
            fu_result = fu_tmp[15:0];
            fu_flags  = {fu_tmp[15:0] == 16'h0, (fu_src[15] == fu_dst[15]) && (fu_tmp[15] != fu_src[15]),
                         fu_tmp[15], fu_tmp[16]};
        end else if (fu_fs == FS_CMP) begin
            fu_tmp    = {1'b0, fu_dst} + {1'b0, ~fu_src} + 17'd1;
            fu_result = fu_tmp[15:0];
            fu_flags  = {fu_tmp[15:0] == 16'h0, (fu_src[15] != fu_dst[15]) && (fu_tmp[15] != fu_dst[15]),
                         fu_tmp[15], fu_tmp[16]};
        end else if (fu_fs == FS_MOV) begin
            fu_result = fu_src;
        end
    end

    // Memory responder: ack after cur_waits wait cycles, reads return rd0 then rd1
    always @(negedge clk) begin
        if (mem_req && wcnt >= cur_waits) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_we ? 16'hEEEE : ((ridx == 0) ? rd0 : rd1);
            if (!mem_we) ridx = ridx + 1;
            wcnt = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'hEEEE;
            wcnt      = mem_req ? wcnt + 1 : 0;
        end
    end

    function automatic void push(input int k, input logic [39:0] v);
        ev_t e;
        e.kind = k;
        e.v    = v;
        sb.push_back(e);
    endfunction

    function automatic void observe(input int k, input logic [39:0] v);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected: actual %h, required no event", knm[k], v);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.v != v) begin
                n_err++;
                $display("FAIL %s: actual %s %h, required %s %h", knm[k], knm[k], v, knm[e.kind], e.v);
            end
        end
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (mem_req && mem_ack)
                observe(mem_we ? K_WR : K_RD,
                        mem_we ? {7'd0, mem_byte, mem_wdata, mem_addr} : {23'd0, mem_byte, mem_addr});
            if (inc_we)   observe(K_INC, {24'd0, inc_val});
            if (reg_we)   observe(K_REGW, {24'd0, reg_wdata});
            if (flags_we) observe(K_FLG, {36'd0, flags_out});
            if (done) begin observe(K_DONE, 40'(cyc - start_c)); done_cnt++; end
            if (error) begin observe(K_ERR, 40'(cyc - start_c)); err_cnt++; end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int t0;
        @(negedge clk);
        fs = v.fs; byte_op = v.bo; src_mode = v.sm; dst_mode = v.dm; dst_wr = v.dwr;
        src_reg = v.sreg; dst_reg = v.dreg; src_idx = v.sidx; dst_idx = v.didx; flags_in = v.fin;
        cur_waits = v.waits; rd0 = v.rd0; rd1 = v.rd1; ridx = 0;
        start = 1'b1; start_c = cyc; t0 = done_cnt;
        if (v.e_mask[0]) push(K_RD, {23'd0, v.bo, v.e_rd0});
        if (v.e_mask[1]) push(K_INC, {24'd0, v.e_inc});
        if (v.e_mask[2]) push(K_RD, {23'd0, v.bo, v.e_rd1});
        if (v.e_mask[3]) push(K_REGW, {24'd0, v.e_regw});
        push(K_FLG, {36'd0, v.e_flg});
        if (v.e_mask[4]) push(K_WR, {7'd0, v.bo, v.e_wd, v.e_wa});
        push(K_DONE, 40'(v.e_lat));
        @(negedge clk);
        start = 1'b0; fs = 16'hFFFF; byte_op = ~byte_op; flags_in = ~flags_in;
        src_reg = 16'hDEAD; dst_reg = 16'hBEEF; src_idx = 16'h5555; dst_idx = 16'hAAAA;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (done_cnt != t0) break;
            @(negedge clk);
        end
        n_cmp++;
        if (done_cnt == t0) begin
            n_err++;
            $display("FAIL vec%0d_done: actual no done, required done within 100 cycles", idx);
        end
        chk($sformatf("vec%0d_events_left", idx), 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        //          fs      bo    sm    dm    dwr   sreg      dreg      sidx      didx      fin      rd0       rd1       w  e_rd0     e_inc     e_rd1     e_regw    e_flg    e_wa      e_wd      mask      lat
        vecs[0] = '{FS_ADD, 1'b0, 2'd0, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 4'b0110, 16'h0000, 16'h0000, 5'b01000, 2};
        vecs[1] = '{FS_MOV, 1'b1, 2'd1, 1'b0, 1'b1, 16'h0200, 16'h1234, 16'h0010, 16'h0000, 4'b1001, 16'hABCD, 16'h0000, 3, 16'h0210, 16'h0000, 16'h0000, 16'h00CD, 4'b1001, 16'h0000, 16'h0000, 5'b01001, 6};
        vecs[2] = '{FS_MOV, 1'b0, 2'd3, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 16'h5A5A, 16'h0000, 0, 16'h0300, 16'h0302, 16'h0000, 16'h5A5A, 4'b0100, 16'h0000, 16'h0000, 5'b01011, 3};
        vecs[3] = '{FS_MOV, 1'b1, 2'd3, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 4'b0010, 16'h12F0, 16'h0000, 1, 16'h0300, 16'h0301, 16'h0000, 16'h00F0, 4'b0010, 16'h0000, 16'h0000, 5'b01011, 4};
        vecs[4] = '{FS_CMP, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0005, 16'h0100, 16'h0000, 16'h0020, 4'b0000, 16'h0005, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0120, 16'h0000, 4'b1001, 16'h0000, 16'h0000, 5'b00100, 3};
        vecs[5] = '{FS_ADD, 1'b0, 2'd0, 1'b1, 1'b1, 16'h0003, 16'h0400, 16'h0000, 16'h0004, 4'b0000, 16'h0005, 16'h0000, 2, 16'h0000, 16'h0000, 16'h0404, 16'h0000, 4'b0000, 16'h0404, 16'h0008, 5'b10100, 8};
        vecs[6] = '{FS_ADD, 1'b0, 2'd2, 1'b1, 1'b1, 16'h0500, 16'h0600, 16'h0000, 16'hFFFE, 4'b0000, 16'h00FF, 16'hFF01, 0, 16'h0500, 16'h0000, 16'h05FE, 16'h0000, 4'b1001, 16'h05FE, 16'h0000, 5'b10101, 5};
        vecs[7] = '{FS_ADD, 1'b0, 2'd1, 1'b0, 1'b1, 16'hFFF0, 16'hFFFF, 16'h0020, 16'h0000, 4'b0000, 16'h0001, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 4'b1001, 16'h0000, 16'h0000, 5'b01001, 3};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_mem", {mem_req, mem_we, mem_byte, mem_addr, mem_wdata}, 64'd0);
        chk("reset_fu", {fu_src, fu_dst, fu_fs, fu_flags_in}, 64'd0);
        chk("reset_ctl", {reg_we, reg_wdata, inc_we, inc_val, flags_we, flags_out, busy, done, error}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while a source read is stalled abandons the instruction
        @(negedge clk);
        fs = FS_MOV; byte_op = 1'b0; src_mode = 2'd1; dst_mode = 1'b0; dst_wr = 1'b1;
        src_reg = 16'h0700; src_idx = 16'h0002; cur_waits = 1000; ridx = 0;
        start = 1'b1; start_c = cyc;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("midrst_req_before", {mem_req, busy}, 64'h3);
        chk("midrst_addr_before", mem_addr, 64'h0702);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst_req_after", mem_req, 64'd0);
        chk("midrst_busy_after", busy, 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        chk("midrst_idle_later", {mem_req, busy, 14'd0, mem_addr}, 64'd0);

`ifdef FU_SEQ_TIMEOUT_EN
        // No ack at all: abort after 15 cycles in SRC_RD, error one cycle later, no done
        begin
            int t0;
            @(negedge clk);
            fs = FS_MOV; src_mode = 2'd1; dst_mode = 1'b0; dst_wr = 1'b1;
            src_reg = 16'h0800; src_idx = 16'h0000; cur_waits = 1000; ridx = 0;
            start = 1'b1; start_c = cyc; t0 = err_cnt;
            push(K_ERR, 40'd16);
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #2;
                if (err_cnt != t0) break;
                @(negedge clk);
            end
            n_cmp++;
            if (err_cnt == t0) begin
                n_err++;
                $display("FAIL timeout_error: actual no error pulse, required pulse within 40 cycles");
            end
            chk("timeout_busy", {mem_req, busy}, 64'd0);
            repeat (4) @(negedge clk);
            #2;
            chk("timeout_events_left", 64'(sb.size()), 64'd0);
            sb.delete();
        end
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
